pipelined_adder: RTL



---
 rtl/pipelined_adder.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder (a + b + cin): the carry chain is cut into STAGES equal slices
// with valid/ready flow control. Define PIPELINED_ADDER_OVF_EN to add the registered ovf output.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int SW = WIDTH / STAGES;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : gen_param_check
        $error("pipelined_adder: need WIDTH >= 2, 1 <= STAGES <= WIDTH and WIDTH %% STAGES == 0");
    end

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] load;

    // load[k]: stage k may capture new data this cycle, either because it is empty or
    // because every stage downstream of it moves. Equivalent to the backward advance chain.
    always_comb begin
        logic full_tail;
        load      = '0;
        full_tail = 1'b1;
        // NOTE: blocking assignments here; full_tail is a running accumulator that each
        // iteration must see already updated, which non-blocking would not give.
        for (int k = STAGES - 1; k >= 0; k--) begin
            full_tail = full_tail && v[k];
            load[k]   = out_ready || !full_tail;
        end
    end

    assign in_ready = load[0] && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            v <= '0;
        end else begin
            if (load[0]) begin
                v[0] <= in_valid;
            end
            for (int k = 1; k < STAGES; k++) begin
                if (load[k]) begin
                    v[k] <= v[k-1];
                end
            end
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : gen_stage
        localparam int SRCW = (STAGES - k) * SW;  // operand bits not yet added on entry
        localparam int SUMW = (k + 1) * SW;

        logic [SRCW-1:0] src_a;
        logic [SRCW-1:0] src_b;
        logic            src_carry;
        logic            src_valid;
        logic [SW:0]     slice_sum;
        logic [SUMW-1:0] sum_next;
        logic [SUMW-1:0] sum_r;
        logic            carry_r;

        if (k == 0) begin : gen_src
            assign src_a     = a;
            assign src_b     = b;
            assign src_carry = cin;
            assign src_valid = in_valid;
            assign sum_next  = slice_sum[SW-1:0];
        end else begin : gen_src
            assign src_a     = gen_stage[k-1].gen_ops.op_a;
            assign src_b     = gen_stage[k-1].gen_ops.op_b;
            assign src_carry = gen_stage[k-1].carry_r;
            assign src_valid = v[k-1];
            assign sum_next  = {slice_sum[SW-1:0], gen_stage[k-1].sum_r};
        end

        assign slice_sum = {1'b0, src_a[SW-1:0]} + {1'b0, src_b[SW-1:0]} + {{SW{1'b0}}, src_carry};

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_r   <= '0;
                carry_r <= 1'b0;
            end else if (load[k] && src_valid) begin
                sum_r   <= sum_next;
                carry_r <= slice_sum[SW];
            end
        end

        if (k < STAGES - 1) begin : gen_ops
            logic [SRCW-SW-1:0] op_a;
            logic [SRCW-SW-1:0] op_b;

            // NOTE: no reset on the operand registers; they are only ever consumed behind a
            // set valid bit, and the visible sum/carry registers above are the ones reset.
            always_ff @(posedge clk) begin
                if (load[k] && src_valid) begin
                    op_a <= src_a[SRCW-1:SW];
                    op_b <= src_b[SRCW-1:SW];
                end
            end
        end
    end

    assign out_valid = v[STAGES-1];
    assign sum       = gen_stage[STAGES-1].sum_r;
    assign cout      = gen_stage[STAGES-1].carry_r;

`ifdef PIPELINED_ADDER_OVF_EN
    // The top slice holds both operand MSBs and produces the sum MSB, so overflow is
    // decided where that slice is added and travels with the result.
    logic ovf_next;

    assign ovf_next = (gen_stage[STAGES-1].src_a[SW-1] == gen_stage[STAGES-1].src_b[SW-1]) &&
                      (gen_stage[STAGES-1].slice_sum[SW-1] != gen_stage[STAGES-1].src_a[SW-1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (load[STAGES-1] && gen_stage[STAGES-1].src_valid) begin
            ovf <= ovf_next;
        end
    end
`endif

endmodule
